// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, load result and flush in, register-file write port and FIFO status out.
interface wb_arbiter_if #(
    parameter int WIDTH_REG  = 5,
    parameter int WIDTH_FIFO = 2
);
    logic                  i_alu_valid;
    logic [WIDTH_REG-1:0]  i_alu_addr;
    logic [31:0]           i_alu_data;
    logic                  i_mem_valid;
    logic [WIDTH_REG-1:0]  i_mem_addr;
    logic [31:0]           i_mem_data;
    logic                  i_flush;
    logic                  o_we;
    logic [WIDTH_REG-1:0]  o_waddr;
    logic [31:0]           o_wdata;
    logic                  o_mem_ready;
    logic [WIDTH_FIFO:0]   o_count;
    logic                  o_overflow;

    // Handshake: a load is taken whenever i_mem_valid=1. o_mem_ready is
    // advisory (FIFO not full); a load presented while full and not
    // drained or bypassed is dropped and flagged on o_overflow.
    modport master (
        output i_alu_valid, i_alu_addr, i_alu_data,
        output i_mem_valid, i_mem_addr, i_mem_data, i_flush,
        input  o_we, o_waddr, o_wdata, o_mem_ready, o_count, o_overflow
    );

    modport slave (
        input  i_alu_valid, i_alu_addr, i_alu_data,
        input  i_mem_valid, i_mem_addr, i_mem_data, i_flush,
        output o_we, o_waddr, o_wdata, o_mem_ready, o_count, o_overflow
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results own the register-file port, load results
// queue in a small FIFO behind them and drain in arrival order.
module wb_arbiter #(
    parameter int WIDTH_REG  = 5,
    parameter int WIDTH_FIFO = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    wb_arbiter_if.slave   bus
);
    localparam int DEPTH = 1 << WIDTH_FIFO;
    localparam logic [WIDTH_FIFO:0] COUNT_FULL = (WIDTH_FIFO+1)'(DEPTH);

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } src_e;

    src_e                   src;
    logic [WIDTH_REG-1:0]   fifo_addr [DEPTH];
    logic [31:0]            fifo_data [DEPTH];
    logic [WIDTH_FIFO-1:0]  rd_ptr;
    logic [WIDTH_FIFO-1:0]  wr_ptr;
    logic [WIDTH_FIFO:0]    count;
    logic                   empty;
    logic                   full;
    logic                   take;
    logic                   pop;
    logic                   push_req;
    logic                   push;
    logic                   drop;
    logic [WIDTH_REG-1:0]   sel_addr;
    logic [31:0]            sel_data;
    logic                   we;
    logic [WIDTH_REG-1:0]   waddr;
    logic [31:0]            wdata;
    logic                   overflow;

    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);

    always_comb begin
        src      = SRC_NONE;
        sel_addr = '0;
        sel_data = '0;
        if (bus.i_alu_valid) begin
            src      = SRC_ALU;
            sel_addr = bus.i_alu_addr;
            sel_data = bus.i_alu_data;
        end else if (!empty) begin
            src      = SRC_FIFO;
            sel_addr = fifo_addr[rd_ptr];
            sel_data = fifo_data[rd_ptr];
        end else if (bus.i_mem_valid) begin
            src      = SRC_BYPASS;
            sel_addr = bus.i_mem_addr;
            sel_data = bus.i_mem_data;
        end
    end

    // Flush cancels any load-side write or pop but never the ALU write.
    always_comb begin
        take     = (src == SRC_ALU) ||
                   (((src == SRC_FIFO) || (src == SRC_BYPASS)) && !bus.i_flush);
        pop      = (src == SRC_FIFO) && !bus.i_flush;
        push_req = bus.i_mem_valid && !bus.i_flush && (src != SRC_BYPASS);
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.i_mem_addr;
            fifo_data[wr_ptr] <= bus.i_mem_data;
        end
    end

    // Register 0 is never written, but the selected source is still consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (take && (sel_addr != '0)) begin
            we    <= 1'b1;
            waddr <= sel_addr;
            wdata <= sel_data;
        end else begin
            we    <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    assign bus.o_we        = we;
    assign bus.o_waddr     = waddr;
    assign bus.o_wdata     = wdata;
    assign bus.o_count     = count;
    assign bus.o_mem_ready = !full;
    assign bus.o_overflow  = overflow;
endmodule
